// File: rtl/ecc_s1d_pkg.sv
// Shared S1D (38,32) code definitions: codeword layout, H-matrix data columns
// and the syndrome lookup used by both the encoder and decoder.
package ecc_s1d_pkg;

  localparam int CW_W  = 38;
  localparam int DW    = 32;
  localparam int CHK_W = 6;

  localparam int unsigned CHK_POS [CHK_W] = '{0, 1, 3, 7, 14, 24};

  localparam int unsigned DATA_POS [DW] = '{
    2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 15, 16, 17, 18, 19, 20,
    21, 22, 23, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37
  };

  localparam logic [CHK_W-1:0] DATA_COL [DW] = '{
    6'h03, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C,
    6'h0D, 6'h0E, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16,
    6'h18, 6'h19, 6'h1A, 6'h21, 6'h22, 6'h24, 6'h26, 6'h28,
    6'h29, 6'h2A, 6'h2C, 6'h30, 6'h31, 6'h32, 6'h34, 6'h38
  };

  typedef enum logic [1:0] {
    SYN_OK,
    SYN_DATA,
    SYN_CHECK,
    SYN_UNCORR
  } syn_class_t;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } syn_hit_t;

  // Maps a syndrome to the data bit whose H-column it equals, if any.
  function automatic syn_hit_t syn_lookup(input logic [CHK_W-1:0] syn);
    syn_hit_t r;
    r = '0;
    for (int i = 0; i < DW; i++) begin
      if (syn == DATA_COL[i]) begin
        r.hit = 1'b1;
        r.idx = 5'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] cw_data(input logic [CW_W-1:0] cw);
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = cw[DATA_POS[i]];
    return d;
  endfunction

endpackage

// File: rtl/ecc_s1d_syndrome.sv
// Combinational S1D syndrome: each check bit XORed with the data bits whose
// H-column covers it.
module ecc_s1d_syndrome
  import ecc_s1d_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [CHK_W-1:0] syn
);

  // NOTE: syn gets a full default before any conditional update so no latch is inferred.
  always_comb begin
    syn = '0;
    for (int k = 0; k < CHK_W; k++) syn[k] = cw[CHK_POS[k]];
    for (int i = 0; i < DW; i++) begin
      if (cw[DATA_POS[i]]) syn = syn ^ DATA_COL[i];
    end
  end

endmodule

// File: rtl/ecc_s1d_decoder_pipe.sv
// Two-stage S1D single-error-correcting decoder with valid/ready flow control
// and saturating CE/UE counters. Define ECC_ERR_LOG_EN to add the first-error log.
module ecc_s1d_decoder_pipe
  import ecc_s1d_pkg::*;
#(
  parameter int AW    = 10,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EDI_VLD,
  output logic             EDI_RDY,
  input  logic [CW_W-1:0]  EDI,
  input  logic [AW-1:0]    ADDR_IN,
  output logic             EDO_VLD,
  input  logic             EDO_RDY,
  output logic [DW-1:0]    EDO,
  output logic [AW-1:0]    ADDR_OUT,
  output logic             CE,
  output logic             UE,
  output logic [CHK_W-1:0] SYN,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] CE_CNT,
  output logic [CNT_W-1:0] UE_CNT
`ifdef ECC_ERR_LOG_EN
  ,
  output logic             LOG_VLD,
  output logic [AW-1:0]    LOG_ADDR,
  output logic [CHK_W-1:0] LOG_SYN,
  output logic             LOG_UE
`endif
);

  logic             s1_vld, s2_vld, s1_adv, s2_adv, xfer;
  logic [CW_W-1:0]  s1_cw;
  logic [AW-1:0]    s1_addr;
  logic [CHK_W-1:0] s1_syn, in_syn;
  logic [DW-1:0]    raw_data, fix_data;
  syn_hit_t         hit;
  syn_class_t       cls;

  ecc_s1d_syndrome u_syndrome (
    .cw  (EDI),
    .syn (in_syn)
  );

  assign s2_adv  = !s2_vld || EDO_RDY;
  assign s1_adv  = !s1_vld || s2_adv;
  assign EDI_RDY = !RST && s1_adv;
  assign EDO_VLD = s2_vld;
  assign xfer    = s2_vld && EDO_RDY;

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld  <= 1'b0;
      s1_cw   <= '0;
      s1_addr <= '0;
      s1_syn  <= '0;
    end else if (s1_adv) begin
      s1_vld <= EDI_VLD;
      if (EDI_VLD) begin
        s1_cw   <= EDI;
        s1_addr <= ADDR_IN;
        s1_syn  <= in_syn;
      end
    end
  end

  always_comb begin
    raw_data = cw_data(s1_cw);
    hit      = syn_lookup(s1_syn);
    fix_data = raw_data;
    cls      = SYN_OK;
    if (s1_syn == '0) begin
      cls = SYN_OK;
    end else if (hit.hit) begin
      cls = SYN_DATA;
      fix_data[hit.idx] = ~raw_data[hit.idx];
    end else if ((s1_syn & (s1_syn - CHK_W'(1))) == '0) begin
      cls = SYN_CHECK;
    end else begin
      cls = SYN_UNCORR;
    end
  end

  // Output registers only load on a real word so they stay frozen while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_vld   <= 1'b0;
      EDO      <= '0;
      ADDR_OUT <= '0;
      CE       <= 1'b0;
      UE       <= 1'b0;
      SYN      <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        EDO      <= fix_data;
        ADDR_OUT <= s1_addr;
        CE       <= (cls == SYN_DATA) || (cls == SYN_CHECK);
        UE       <= (cls == SYN_UNCORR);
        SYN      <= s1_syn;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      CE_CNT <= '0;
      UE_CNT <= '0;
    end else begin
      if (xfer && CE && (CE_CNT != '1)) CE_CNT <= CE_CNT + CNT_W'(1);
      if (xfer && UE && (UE_CNT != '1)) UE_CNT <= UE_CNT + CNT_W'(1);
    end
  end

`ifdef ECC_ERR_LOG_EN
  // First event is captured; a UE may replace a logged CE once, then it freezes.
  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      LOG_VLD  <= 1'b0;
      LOG_ADDR <= '0;
      LOG_SYN  <= '0;
      LOG_UE   <= 1'b0;
    end else if (xfer && (CE || UE) && (!LOG_VLD || (UE && !LOG_UE))) begin
      LOG_VLD  <= 1'b1;
      LOG_ADDR <= ADDR_OUT;
      LOG_SYN  <= SYN;
      LOG_UE   <= UE;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_s1d_decoder_pipe.sv
// Directed bench for ecc_s1d_decoder_pipe: independent encoder model, scoreboard
// queue, stall-stability monitor and counter saturation/clear checks.
module tb_ecc_s1d_decoder_pipe;

  localparam int AW    = 10;
  localparam int CNT_W = 16;

  localparam int TB_CHK [6] = '{0, 1, 3, 7, 14, 24};
  localparam logic [5:0] TB_COL [32] = '{
    6'h03, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C,
    6'h0D, 6'h0E, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16,
    6'h18, 6'h19, 6'h1A, 6'h21, 6'h22, 6'h24, 6'h26, 6'h28,
    6'h29, 6'h2A, 6'h2C, 6'h30, 6'h31, 6'h32, 6'h34, 6'h38
  };

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EDI_VLD = 1'b0;
  logic             EDO_RDY = 1'b1;
  logic             CNT_CLR = 1'b0;
  logic [37:0]      EDI = '0;
  logic [AW-1:0]    ADDR_IN = '0;
  logic             EDI_RDY, EDO_VLD, CE, UE;
  logic [31:0]      EDO;
  logic [AW-1:0]    ADDR_OUT;
  logic [5:0]       SYN;
  logic [CNT_W-1:0] CE_CNT, UE_CNT;
`ifdef ECC_ERR_LOG_EN
  logic             LOG_VLD, LOG_UE;
  logic [AW-1:0]    LOG_ADDR;
  logic [5:0]       LOG_SYN;
`endif

  ecc_s1d_decoder_pipe #(.AW(AW), .CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EDI_VLD  (EDI_VLD),
    .EDI_RDY  (EDI_RDY),
    .EDI      (EDI),
    .ADDR_IN  (ADDR_IN),
    .EDO_VLD  (EDO_VLD),
    .EDO_RDY  (EDO_RDY),
    .EDO      (EDO),
    .ADDR_OUT (ADDR_OUT),
    .CE       (CE),
    .UE       (UE),
    .SYN      (SYN),
    .CNT_CLR  (CNT_CLR),
    .CE_CNT   (CE_CNT),
    .UE_CNT   (UE_CNT)
`ifdef ECC_ERR_LOG_EN
    ,
    .LOG_VLD  (LOG_VLD),
    .LOG_ADDR (LOG_ADDR),
    .LOG_SYN  (LOG_SYN),
    .LOG_UE   (LOG_UE)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
    logic          ce;
    logic          ue;
    logic [5:0]    syn;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e, held_e;
  bit   held = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_ce = 0;
  int   exp_ue = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int chk_idx(input int p);
    int r = -1;
    for (int k = 0; k < 6; k++) if (TB_CHK[k] == p) r = k;
    return r;
  endfunction

  function automatic logic [37:0] encode(input logic [31:0] d);
    logic [5:0]  c = '0;
    logic [37:0] cw = '0;
    int          j = 0;
    int          k;
    for (int i = 0; i < 32; i++) if (d[i]) c = c ^ TB_COL[i];
    for (int p = 0; p < 38; p++) begin
      k = chk_idx(p);
      if (k >= 0) cw[p] = c[k];
      else begin
        cw[p] = d[j];
        j++;
      end
    end
    return cw;
  endfunction

  // Syndrome produced by flipping codeword position p of a clean word.
  function automatic logic [5:0] pos_syn(input int p);
    int         k = chk_idx(p);
    int         j = 0;
    logic [5:0] s;
    for (int q = 0; q < p; q++) if (chk_idx(q) < 0) j++;
    if (k >= 0) s = 6'(1 << k);
    else s = TB_COL[j];
    return s;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic [AW-1:0] a,
                              input logic ce, input logic ue, input logic [5:0] s);
    exp_t e;
    e.data = d; e.addr = a; e.ce = ce; e.ue = ue; e.syn = s;
    e.acc_cyc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_t x = e;
    x.acc_cyc = cyc;
    sbq.push_back(x);
    if (x.ce && exp_ce < 65535) exp_ce++;
    if (x.ue && exp_ue < 65535) exp_ue++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [37:0] cw, input exp_t e);
    bit acc = 1'b0;
    int n = 0;
    EDI_VLD = 1'b1; EDI = cw; ADDR_IN = e.addr;
    while (!acc && n < 50) begin
      @(negedge CLK);
      if (EDI_RDY) begin
        push(e);
        acc = 1'b1;
      end
      step();
      n++;
    end
    EDI_VLD = 1'b0;
    if (!acc) check("accept_timeout", EDI_RDY, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", sbq.size(), 0);
    repeat (2) step();
  endtask

  task automatic stream(input int n, input bit toggle, input bit fixed);
    int          sent = 0;
    int          cnt = 0;
    int          p;
    bit          need = 1'b1;
    logic [31:0] d;
    logic [37:0] cw;
    exp_t        e;
    while (sent < n && cnt < n * 3 + 20) begin
      if (need) begin
        if (fixed) begin
          cw = 38'h3;
          e  = mk(32'h1, AW'(sent), 1'b1, 1'b0, 6'h03);
        end else begin
          d  = $urandom;
          p  = (sent == 0) ? -1 : int'($urandom_range(0, 37));
          cw = encode(d);
          if (p >= 0) begin
            cw[p] = ~cw[p];
            e = mk(d, AW'(sent + 64), 1'b1, 1'b0, pos_syn(p));
          end else begin
            e = mk(d, AW'(sent + 64), 1'b0, 1'b0, 6'h00);
          end
        end
        need = 1'b0;
      end
      EDO_RDY = toggle ? ((cnt % 2) == 0) : 1'b1;
      EDI_VLD = 1'b1; EDI = cw; ADDR_IN = e.addr;
      @(negedge CLK);
      if (EDI_RDY) begin
        push(e);
        sent++;
        need = 1'b1;
      end
      step();
      cnt++;
    end
    EDI_VLD = 1'b0;
    EDO_RDY = 1'b1;
    if (toggle) check("stream_sent", sent, n);
    else check("throughput", cnt, n);
  endtask

  // Output monitor: scoreboard pop on transfer, hold check while stalled.
  always @(negedge CLK) begin
    if (RST) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_vld", EDO_VLD, 1);
        check("stall_edo", EDO, held_e.data);
        check("stall_addr", ADDR_OUT, held_e.addr);
        check("stall_ce", CE, held_e.ce);
        check("stall_ue", UE, held_e.ue);
        check("stall_syn", SYN, held_e.syn);
      end
      if (EDO_VLD && EDO_RDY) begin
        if (sbq.size() == 0) begin
          check("spurious_out", EDO_VLD, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("edo", EDO, mon_e.data);
          check("addr_out", ADDR_OUT, mon_e.addr);
          check("ce", CE, mon_e.ce);
          check("ue", UE, mon_e.ue);
          check("syn", SYN, mon_e.syn);
          if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, 2);
        end
      end
      held = EDO_VLD && !EDO_RDY;
      held_e.data = EDO; held_e.addr = ADDR_OUT;
      held_e.ce = CE; held_e.ue = UE; held_e.syn = SYN;
    end
  end

  initial begin
    exp_t        e;
    logic [37:0] cw;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_edi_rdy", EDI_RDY, 0);
    check("rst_edo_vld", EDO_VLD, 0);
    check("rst_edo", EDO, 0);
    check("rst_syn", SYN, 0);
    check("rst_ce_ue", {CE, UE}, 0);
    check("rst_ce_cnt", CE_CNT, 0);
    check("rst_ue_cnt", UE_CNT, 0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("rdy_after_rst", EDI_RDY, 1);
    step();

    // Clean word, latency
    e = mk(32'h1, 10'h011, 1'b0, 1'b0, 6'h00);
    e.chk_lat = 1'b1;
    send(38'h00_0000_0007, e);
    drain();

    // d0 flipped
    send(38'h00_0000_0003, mk(32'h1, 10'h012, 1'b1, 1'b0, 6'h03));
    drain();
    @(negedge CLK);
    check("ce_cnt_d0", CE_CNT, exp_ce);
    step();

    // check bit 5 flipped
    send(38'h00_0100_0000, mk(32'h0, 10'h013, 1'b1, 1'b0, 6'h20));
    drain();

    // double error -> uncorrectable
    send(38'h20_0000_0040, mk(32'h8000_0008, 10'h014, 1'b0, 1'b1, 6'h3F));
    drain();
    @(negedge CLK);
    check("ce_cnt_chk", CE_CNT, exp_ce);
    check("ue_cnt_1", UE_CNT, exp_ue);
`ifdef ECC_ERR_LOG_EN
    check("log_vld_ue", LOG_VLD, 1);
    check("log_ue", LOG_UE, 1);
    check("log_syn_ue", LOG_SYN, 6'h3F);
    check("log_addr_ue", LOG_ADDR, 10'h014);
`endif
    step();

    // 8-word stream with EDO_RDY toggling
    stream(8, 1'b1, 1'b0);
    drain();
    @(negedge CLK);
    check("ce_cnt_stream", CE_CNT, exp_ce);
`ifdef ECC_ERR_LOG_EN
    check("log_frozen_addr", LOG_ADDR, 10'h014);
`endif
    step();

    // Saturation: fill to all-ones, then one more
    stream(65535 - exp_ce, 1'b0, 1'b1);
    drain();
    @(negedge CLK);
    check("ce_cnt_full", CE_CNT, 16'hFFFF);
    step();
    stream(1, 1'b0, 1'b1);
    drain();
    @(negedge CLK);
    check("ce_cnt_sat", CE_CNT, 16'hFFFF);
    step();

    // CNT_CLR on the same edge as a CE transfer
    EDO_RDY = 1'b0;
    send(38'h00_0000_0003, mk(32'h1, 10'h020, 1'b1, 1'b0, 6'h03));
    for (int n = 0; n < 10 && !EDO_VLD; n++) step();
    check("clr_stalled_vld", EDO_VLD, 1);
    EDO_RDY = 1'b1;
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    exp_ce = 0;
    exp_ue = 0;
    @(negedge CLK);
    check("ce_cnt_clr", CE_CNT, 0);
    check("ue_cnt_clr", UE_CNT, 0);
`ifdef ECC_ERR_LOG_EN
    check("log_clr", LOG_VLD, 0);
`endif
    step();

    // Single CE after clear
    cw = encode(32'hA5A5_0000);
    cw[10] = ~cw[10];
    send(cw, mk(32'hA5A5_0000, 10'h021, 1'b1, 1'b0, pos_syn(10)));
    drain();
    @(negedge CLK);
    check("ce_cnt_after_clr", CE_CNT, exp_ce);
`ifdef ECC_ERR_LOG_EN
    check("log_vld_ce", LOG_VLD, 1);
    check("log_ue_ce", LOG_UE, 0);
    check("log_syn_ce", LOG_SYN, pos_syn(10));
    check("log_addr_ce", LOG_ADDR, 10'h021);
`endif
    step();

    // Full pipe stalls input, then reset mid-stream discards it
    EDO_RDY = 1'b0;
    send(encode(32'h1111_2222), mk(32'h1111_2222, 10'h030, 1'b0, 1'b0, 6'h00));
    send(encode(32'h3333_4444), mk(32'h3333_4444, 10'h031, 1'b0, 1'b0, 6'h00));
    @(negedge CLK);
    check("full_edi_rdy", EDI_RDY, 0);
    step();
    RST = 1'b1;
    sbq.delete();
    exp_ce = 0;
    exp_ue = 0;
    @(negedge CLK);
    check("rst_mid_edi_rdy", EDI_RDY, 0);
    step();
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_vld", EDO_VLD, 0);
    check("rst_mid_ce_cnt", CE_CNT, 0);
    check("rst_mid_rdy", EDI_RDY, 1);
    step();
    EDO_RDY = 1'b1;
    repeat (5) step();
    send(encode(32'hDEAD_BEEF), mk(32'hDEAD_BEEF, 10'h040, 1'b0, 1'b0, 6'h00));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_s1d_decoder_pipe.md
Name: ecc_s1d_decoder_pipe

Overview:
Pipelined single-error-correcting decoder for the 38-bit S1D codeword (32 data + 6 check bits) read back from the 22nm memory macro. It sits directly downstream of the memory read port and upstream of the wrapper's read-data bus. Per word it computes the syndrome, corrects any single-bit error, and flags uncorrectable words. It also keeps saturating corrected/uncorrectable event counters.

Parameters:
AW, 10, width of the address tag carried alongside each word
CNT_W, 16, width of each saturating error counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
EDI_VLD  in  1  input codeword valid
EDI_RDY  out  1  decoder can accept input this cycle
EDI  in  38  received codeword
ADDR_IN  in  AW  address tag for EDI
EDO_VLD  out  1  output word valid
EDO_RDY  in  1  consumer accepts output
EDO  out  32  corrected data
ADDR_OUT  out  AW  tag aligned with EDO
CE  out  1  single-bit error corrected (qualified by EDO_VLD)
UE  out  1  uncorrectable syndrome (qualified by EDO_VLD)
SYN  out  6  syndrome of the current output word
CNT_CLR  in  1  synchronous clear of counters and log
CE_CNT  out  CNT_W  corrected-event count
UE_CNT  out  CNT_W  uncorrectable-event count

Behaviour:
- Clocking: one clock CLK. RST is synchronous and active-high.
- Codeword layout: check bit k sits at codeword positions 0, 1, 3, 7, 14 and 24 (k = 0..5). Data bits d0..d31 fill the remaining positions in ascending order.
- Syndrome: SYN[k] = check bit k XOR the data bits whose H-column has bit k set.
- Check-bit columns are one-hot (01, 02, 04, 08, 10, 20).
- Data columns in hex, d0..d31: 03 05 06 07 09 0A 0B 0C 0D 0E 11 12 13 14 15 16 18 19 1A 21 22 24 26 28 29 2A 2C 30 31 32 34 38.
- Decode per word:
  - SYN = 0: no error. EDO = raw data, CE = 0, UE = 0.
  - SYN matches a data column: flip that data bit, CE = 1.
  - SYN one-hot: check-bit error. Data passes unchanged, CE = 1.
  - Any other nonzero SYN: UE = 1. EDO = raw uncorrected data.
- Pipeline:
  - Stage 1 registers the codeword, tag and syndrome.
  - Stage 2 registers corrected data, CE, UE, SYN and tag.
  - Latency is 2 cycles from the accepting edge to EDO_VLD when EDO_RDY is held high. Throughput is 1 word per cycle.
- Handshake:
  - A stage advances when it is empty or its successor advances.
  - EDI_RDY = !s1_vld | s1_adv, derived combinationally from EDO_RDY.
  - While EDO_VLD = 1 and EDO_RDY = 0, EDO, ADDR_OUT, CE, UE and SYN hold stable.
  - A transfer occurs only on VLD & RDY. No word is dropped or duplicated under any stall pattern.
- Counters:
  - Increment only on an output transfer with CE (or UE) = 1.
  - Saturate at all-ones with no wrap.
  - CNT_CLR zeroes both counters and takes priority over a same-cycle increment; that event is not counted.
- Reset:
  - All valids, EDO, ADDR_OUT, CE, UE, SYN, CE_CNT and UE_CNT are 0.
  - EDI_RDY = 1 in the cycle after reset deasserts. During reset EDI_RDY = 0.
  - RST mid-stream discards in-flight words.

Optional Feature:
ECC_ERR_LOG_EN
- With the macro defined, add outputs LOG_VLD (1), LOG_ADDR (AW), LOG_SYN (6) and LOG_UE (1).
- The first CE or UE output transfer after reset or CNT_CLR captures its address, syndrome and UE flag, and sets LOG_VLD.
- Later CEs do not overwrite the log. A UE overwrites a logged CE once, then the log is frozen.
- CNT_CLR and RST clear the log.
- Without the macro these ports and registers do not exist, and the core behaviour is identical.

Decomposition:
- Package ecc_s1d_pkg holds:
  - the codeword and data width constants (38, 32);
  - the check-bit position constants;
  - the 32-entry data-column syndrome table;
  - a syndrome-to-bit-index lookup function.
- The package is shared with the encoder side.
- Sub-module ecc_s1d_syndrome: combinational codeword-to-SYN logic, instantiated in stage 1.

Test Plan:
- Codeword 0x00_0000_0007 (data 0x1), EDO_RDY = 1 -> EDO = 0x00000001, CE = 0, UE = 0, SYN = 0, EDO_VLD 2 cycles after accept.
- Codeword 0x00_0000_0003 (d0 flipped) -> EDO = 0x00000001, CE = 1, SYN = 0x03, CE_CNT = 1.
- Codeword 0x00_0100_0000 (bit 24 = check 5 flipped, data 0) -> EDO = 0, CE = 1, SYN = 0x20.
- Codeword 0x20_0000_0040 (d3 and d31 set, checks 0) -> SYN = 0x3F, UE = 1, EDO = 0x80000008, UE_CNT = 1; with ECC_ERR_LOG_EN, LOG_UE = 1.
- Back-to-back stream of 8 words with EDO_RDY toggling 1/0 -> all 8 words appear in order, no duplicates, and outputs hold stable while stalled.
- Preload CE_CNT to 0xFFFF via 65535 CE transfers, then one more -> stays 0xFFFF. Assert CNT_CLR in the same cycle as a CE transfer -> CE_CNT = 0.
